// File: rtl/fifo_pkg.sv
// Shared definitions for the 2-bit FIFO and its downstream packer.
package fifo_pkg;

    localparam int LANE_W = 2;
    localparam int LANES  = 4;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } pack_state_e;

endpackage

// File: rtl/fifo_packer_if.sv
// FIFO read port plus packed-beat output port of the packer.
// The master side is the packer, the slave side is the FIFO/consumer.
interface fifo_packer_if #(
    parameter int LANE_W = fifo_pkg::LANE_W,
    parameter int LANES  = fifo_pkg::LANES
);
    localparam int CNT_W = $clog2(LANES) + 1;

    logic                     empty;
    logic [LANE_W-1:0]        rd_data;
    logic                     rd_en;
    logic                     flush;
    logic [LANE_W*LANES-1:0]  out_data;
    logic [CNT_W-1:0]         out_count;
    logic                     out_valid;
    logic                     out_ready;
    logic [7:0]               beat_cnt;

    modport master (
        input  empty, rd_data, flush, out_ready,
        output rd_en, out_data, out_count, out_valid, beat_cnt
    );

    modport slave (
        output empty, rd_data, flush, out_ready,
        input  rd_en, out_data, out_count, out_valid, beat_cnt
    );

endinterface

// File: rtl/fifo_packer.sv
// Drains a show-ahead FIFO and packs consecutive entries LSB-first into
// wide beats; a flush pulse forces out a zero-padded partial beat.
//
// state   | meaning
// --------+----------------------------------------------------------
// COLLECT | popping entries into acc lanes, idx = next lane to fill
// SEND    | out_data/out_count held, out_valid high, waiting for ready
module fifo_packer #(
    parameter int LANE_W = fifo_pkg::LANE_W,
    parameter int LANES  = fifo_pkg::LANES
) (
    input  logic              clk,
    input  logic              reset_n,
    fifo_packer_if.master     bus
);
    import fifo_pkg::*;

    localparam int IDX_W  = $clog2(LANES);
    localparam int CNT_W  = IDX_W + 1;
    localparam int DATA_W = LANE_W * LANES;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    pack_state_e        state;
    pack_state_e        state_next;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  acc;
    logic [DATA_W-1:0]  acc_fill;
    logic [CNT_W-1:0]   fill_count;
    logic               pop;
    logic               emit;
    logic               handshake;

    // Pop/emit decode and the accumulator with the current pop merged in.
    // reset_n gates pop so rd_en stays low while reset is held.
    always_comb begin
        pop        = (state == COLLECT) && !bus.empty && reset_n;
        handshake  = (state == SEND) && bus.out_ready;
        emit       = (state == COLLECT) &&
                     ((pop && (idx == LAST_IDX)) || (bus.flush && (pop || (idx != '0))));
        fill_count = pop ? (CNT_W'(idx) + CNT_W'(1)) : CNT_W'(idx);
        acc_fill   = acc;
        for (int i = 0; i < LANES; i++) begin
            if (pop && (idx == IDX_W'(i))) begin
                acc_fill[i*LANE_W +: LANE_W] = bus.rd_data;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (emit)      state_next = SEND;
            SEND:    if (handshake) state_next = COLLECT;
            default:                state_next = COLLECT;
        endcase
    end

    // FSM outputs: pop only while collecting, beat valid only while sending.
    always_comb begin
        bus.rd_en     = pop;
        bus.out_valid = (state == SEND);
    end

    // Lane counter, accumulator and the latched output beat.
    // acc is cleared on handshake so a later partial beat is zero-padded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx           <= '0;
            acc           <= '0;
            bus.out_data  <= '0;
            bus.out_count <= '0;
        end else if (state == COLLECT) begin
            if (emit) begin
                idx           <= '0;
                acc           <= acc_fill;
                bus.out_data  <= acc_fill;
                bus.out_count <= fill_count;
            end else if (pop) begin
                idx <= idx + IDX_W'(1);
                acc <= acc_fill;
            end
        end else if (handshake) begin
            acc <= '0;
        end
    end

    // Completed-handshake counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.beat_cnt <= 8'd0;
        end else if (handshake) begin
            bus.beat_cnt <= bus.beat_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_fifo_packer.sv
// Self-checking bench for fifo_packer: a queue models the show-ahead FIFO,
// expected beats go into a scoreboard and are compared on each handshake.
module tb_fifo_packer;
    import fifo_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] cnt;
    } beat_t;

    logic clk;
    logic reset_n;

    fifo_packer_if #(.LANE_W(2), .LANES(4)) ifc ();

    fifo_packer #(.LANE_W(2), .LANES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc)
    );

    lane_t fifo_q[$];
    beat_t sb[$];
    int    nchecks;
    int    nerrors;
    int    rd_cnt;
    int    valid_cnt;
    logic [7:0] exp_beat_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic refresh();
        ifc.empty   = (fifo_q.size() == 0);
        ifc.rd_data = (fifo_q.size() == 0) ? 2'b00 : fifo_q[0];
    endtask

    task automatic push(input lane_t v);
        fifo_q.push_back(v);
        refresh();
    endtask

    task automatic expect_beat(input logic [7:0] d, input logic [2:0] c);
        beat_t b;
        b.data = d;
        b.cnt  = c;
        sb.push_back(b);
    endtask

    // One clock: sample pre-edge, pop the FIFO model, compare on handshake.
    task automatic tick();
        logic  re;
        logic  hs;
        beat_t e;
        #1;
        re = ifc.rd_en;
        hs = ifc.out_valid && ifc.out_ready;
        nchecks++;
        if (re && ifc.empty) begin
            nerrors++;
            $display("FAIL rd_en_while_empty: rd_en=%b empty=%b", re, ifc.empty);
        end
        if (re) rd_cnt++;
        if (ifc.out_valid) valid_cnt++;
        if (hs) begin
            nchecks++;
            if (sb.size() == 0) begin
                nerrors++;
                $display("FAIL unexpected_beat: got data=%h count=%0d, expected no beat", ifc.out_data, ifc.out_count);
            end else begin
                e = sb.pop_front();
                if (ifc.out_data !== e.data || ifc.out_count !== e.cnt) begin
                    nerrors++;
                    $display("FAIL beat_content: got data=%h count=%0d, expected data=%h count=%0d", ifc.out_data, ifc.out_count, e.data, e.cnt);
                end
            end
            exp_beat_cnt = exp_beat_cnt + 8'd1;
        end
        @(posedge clk);
        if (re && fifo_q.size() > 0) void'(fifo_q.pop_front());
        #1;
        refresh();
        nchecks++;
        if (ifc.beat_cnt !== exp_beat_cnt) begin
            nerrors++;
            $display("FAIL beat_cnt: got %0d expected %0d", ifc.beat_cnt, exp_beat_cnt);
        end
    endtask

    task automatic run_until_drained(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        nchecks++;
        if (sb.size() != 0) begin
            nerrors++;
            $display("FAIL drain_timeout: got %0d beats pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_beat_cnt = 8'd0;
        sb.delete();
        fifo_q.delete();
        refresh();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push(2'b01);
        #1;
        nchecks++;
        if (ifc.rd_en !== 1'b0 || ifc.out_valid !== 1'b0) begin
            nerrors++;
            $display("FAIL reset_ctrl: got rd_en=%b out_valid=%b expected 0 0", ifc.rd_en, ifc.out_valid);
        end
        nchecks++;
        if (ifc.out_data !== 8'h00 || ifc.out_count !== 3'd0 || ifc.beat_cnt !== 8'd0) begin
            nerrors++;
            $display("FAIL reset_data: got data=%h count=%0d beat_cnt=%0d expected 0 0 0", ifc.out_data, ifc.out_count, ifc.beat_cnt);
        end
        do_reset();
    endtask

    task automatic test_full_beat();
        ifc.out_ready = 1'b1;
        rd_cnt = 0;
        valid_cnt = 0;
        push(2'b01); push(2'b10); push(2'b11); push(2'b00);
        expect_beat(8'b00_11_10_01, 3'd4);
        run_until_drained(20);
        nchecks++;
        if (rd_cnt != 4 || valid_cnt != 1) begin
            nerrors++;
            $display("FAIL full_beat_cycles: got rd_en=%0d valid=%0d expected 4 1", rd_cnt, valid_cnt);
        end
    endtask

    task automatic test_backpressure();
        ifc.out_ready = 1'b0;
        push(2'b01); push(2'b10); push(2'b11); push(2'b00);
        push(2'b11); push(2'b00); push(2'b01); push(2'b10);
        expect_beat(8'b00_11_10_01, 3'd4);
        expect_beat(8'b10_01_00_11, 3'd4);
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            nchecks++;
            if (ifc.out_valid !== 1'b1 || ifc.out_data !== 8'b00_11_10_01 || ifc.rd_en !== 1'b0 || fifo_q.size() != 4) begin
                nerrors++;
                $display("FAIL backpressure_hold: got valid=%b data=%h rd_en=%b fifo=%0d expected 1 39 0 4", ifc.out_valid, ifc.out_data, ifc.rd_en, fifo_q.size());
            end
        end
        ifc.out_ready = 1'b1;
        run_until_drained(30);
    endtask

    task automatic test_partial_flush();
        ifc.out_ready = 1'b1;
        push(2'b11); push(2'b01);
        expect_beat(8'b00_00_01_11, 3'd2);
        repeat (3) tick();
        ifc.flush = 1'b1;
        tick();
        ifc.flush = 1'b0;
        run_until_drained(10);
        valid_cnt = 0;
        ifc.flush = 1'b1;
        tick();
        ifc.flush = 1'b0;
        repeat (3) tick();
        nchecks++;
        if (valid_cnt != 0) begin
            nerrors++;
            $display("FAIL empty_flush: got %0d valid cycles expected 0", valid_cnt);
        end
    endtask

    task automatic test_flush_pop();
        ifc.out_ready = 1'b1;
        push(2'b01); push(2'b01);
        expect_beat(8'b00_10_01_01, 3'd3);
        repeat (2) tick();
        push(2'b10);
        ifc.flush = 1'b1;
        tick();
        ifc.flush = 1'b0;
        run_until_drained(10);
        push(2'b10); push(2'b10); push(2'b10);
        expect_beat(8'b10_10_10_10, 3'd4);
        repeat (3) tick();
        push(2'b10);
        ifc.flush = 1'b1;
        tick();
        ifc.flush = 1'b0;
        run_until_drained(10);
    endtask

    task automatic test_flush_in_send();
        ifc.out_ready = 1'b0;
        push(2'b01); push(2'b01); push(2'b01); push(2'b01);
        expect_beat(8'h55, 3'd4);
        repeat (4) tick();
        ifc.flush = 1'b1;
        tick();
        ifc.flush = 1'b0;
        repeat (2) tick();
        ifc.out_ready = 1'b1;
        run_until_drained(10);
        valid_cnt = 0;
        repeat (3) tick();
        nchecks++;
        if (valid_cnt != 0) begin
            nerrors++;
            $display("FAIL flush_in_send_remembered: got %0d valid cycles expected 0", valid_cnt);
        end
    endtask

    task automatic test_reset_mid();
        ifc.out_ready = 1'b1;
        push(2'b11); push(2'b11); push(2'b11);
        repeat (3) tick();
        #2;
        push(2'b10);
        reset_n = 1'b0;
        exp_beat_cnt = 8'd0;
        #1;
        nchecks++;
        if (ifc.rd_en !== 1'b0 || ifc.out_valid !== 1'b0 || ifc.out_data !== 8'h00 || ifc.out_count !== 3'd0 || ifc.beat_cnt !== 8'd0) begin
            nerrors++;
            $display("FAIL reset_mid: got rd_en=%b valid=%b data=%h count=%0d beat_cnt=%0d expected all 0", ifc.rd_en, ifc.out_valid, ifc.out_data, ifc.out_count, ifc.beat_cnt);
        end
        do_reset();
        push(2'b01); push(2'b00); push(2'b01); push(2'b00);
        expect_beat(8'b00_01_00_01, 3'd4);
        run_until_drained(20);
    endtask

    task automatic test_wrap();
        lane_t v[4];
        do_reset();
        ifc.out_ready = 1'b1;
        for (int b = 0; b < 256; b++) begin
            for (int k = 0; k < 4; k++) begin
                v[k] = lane_t'($urandom_range(3, 0));
                push(v[k]);
            end
            expect_beat({v[3], v[2], v[1], v[0]}, 3'd4);
            repeat (5) tick();
        end
        nchecks++;
        if (ifc.beat_cnt !== 8'd0 || sb.size() != 0) begin
            nerrors++;
            $display("FAIL wrap: got beat_cnt=%0d pending=%0d expected 0 0", ifc.beat_cnt, sb.size());
        end
    endtask

    initial begin
        nchecks = 0;
        nerrors = 0;
        rd_cnt = 0;
        valid_cnt = 0;
        exp_beat_cnt = 8'd0;
        reset_n = 1'b0;
        ifc.flush = 1'b0;
        ifc.out_ready = 1'b0;
        refresh();
        test_reset();
        test_full_beat();
        test_backpressure();
        test_partial_flush();
        test_flush_pop();
        test_flush_in_send();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
